// File: rtl/mem_access_ctrl_if.sv
// Bundle of signals between the MEM-stage pipeline, the data memory, and the
// MEM/WB register and hazard logic, as seen by the access controller.
interface mem_access_ctrl_if #(
  parameter int PC_BITS = 32
);
  logic               mem_read_m;
  logic               mem_write_m;
  logic [PC_BITS-1:0] alu_out_m;
  logic [PC_BITS-1:0] write_data_m;
  logic               dmem_req;
  logic               dmem_we;
  logic [PC_BITS-1:0] dmem_addr;
  logic [PC_BITS-1:0] dmem_wdata;
  logic               dmem_ack;
  logic [PC_BITS-1:0] dmem_rdata;
  logic [PC_BITS-1:0] read_data_m;
  logic               stall_mem;
  logic               bubble_wb;
  logic               timeout_err;

  modport slave (
    input  mem_read_m, mem_write_m, alu_out_m, write_data_m, dmem_ack, dmem_rdata,
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, read_data_m, stall_mem,
           bubble_wb, timeout_err
  );

  modport master (
    output mem_read_m, mem_write_m, alu_out_m, write_data_m, dmem_ack, dmem_rdata,
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, read_data_m, stall_mem,
           bubble_wb, timeout_err
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access sequencer: IDLE -> REQ -> DONE per access,
// stalling upstream and bubbling MEM/WB until the memory acks or times out.
module mem_access_ctrl #(
  parameter int PC_BITS = 32,
  parameter int TIMEOUT = 255,
  parameter int TO_BITS = 16
) (
  input  logic                clk,
  input  logic                rst,
  mem_access_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;

  localparam logic [TO_BITS-1:0] TO_LAST = TO_BITS'(TIMEOUT - 1);

  state_e               state_q, state_d;
  logic [TO_BITS-1:0]   cnt_q, cnt_d;
  logic                 req_q, req_d;
  logic                 we_q, we_d;
  logic                 terr_q, terr_d;
  logic [PC_BITS-1:0]   addr_q, addr_d;
  logic [PC_BITS-1:0]   wdata_q, wdata_d;
  logic [PC_BITS-1:0]   rdata_q, rdata_d;
  logic                 access;
  logic                 stall;

  assign access = bus.mem_read_m | bus.mem_write_m;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    terr_d  = terr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    stall   = 1'b0;
    case (state_q)
      IDLE: begin
        if (access) begin
          stall   = 1'b1;
          state_d = REQ;
          req_d   = 1'b1;
          we_d    = bus.mem_write_m;
          addr_d  = bus.alu_out_m;
          wdata_d = bus.write_data_m;
          cnt_d   = '0;
        end
      end
      REQ: begin
        stall = 1'b1;
        if (bus.dmem_ack) begin
          req_d   = 1'b0;
          state_d = DONE;
          if (!we_q) rdata_d = bus.dmem_rdata;
        end else if (cnt_q == TO_LAST) begin
          // Abort: zero the load result so MEM/WB never sees stale data.
          req_d   = 1'b0;
          terr_d  = 1'b1;
          rdata_d = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      terr_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      terr_q  <= terr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Hazard outputs are held low while reset is asserted.
  assign bus.stall_mem   = rst & stall;
  assign bus.bubble_wb   = rst & stall;
  assign bus.dmem_req    = req_q;
  assign bus.dmem_we     = we_q;
  assign bus.dmem_addr   = addr_q;
  assign bus.dmem_wdata  = wdata_q;
  assign bus.read_data_m = rdata_q;
  assign bus.timeout_err = terr_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: stimulus pushes expected transactions,
// a negedge monitor pops and checks each one when the access completes.
module tb_mem_access_ctrl;
  localparam int PC_BITS = 32;
  localparam int TIMEOUT = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_access_ctrl_if #(.PC_BITS(PC_BITS)) bus ();

  mem_access_ctrl #(.PC_BITS(PC_BITS), .TIMEOUT(TIMEOUT), .TO_BITS(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        terr;
    int          req_cycles;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] m_rdata = '0;
  logic        m_terr  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.mem_read_m  = 1'b0;
    bus.mem_write_m = 1'b0;
    bus.dmem_ack    = 1'b0;
    for (int i = 0; i < n; i++) tick;
  endtask

  // Issue one access from IDLE; ack_n = REQ cycle carrying the ack, 0 = never.
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata,
                           input int ack_n, input logic late_ack);
    exp_t e;
    rst              = 1'b1;
    bus.mem_read_m   = rd;
    bus.mem_write_m  = wr;
    bus.alu_out_m    = addr;
    bus.write_data_m = wdata;
    bus.dmem_ack     = 1'b0;
    e.we = wr; e.addr = addr; e.wdata = wdata;
    if (ack_n == 0) begin
      m_rdata = '0; m_terr = 1'b1; e.req_cycles = TIMEOUT;
    end else begin
      if (!wr) m_rdata = rdata;
      e.req_cycles = ack_n;
    end
    e.rdata = m_rdata; e.terr = m_terr;
    sb.push_back(e);
    #1;
    chk("stall_issue", bus.stall_mem, 1'b1);
    chk("bubble_issue", bus.bubble_wb, 1'b1);
    tick;
    chk("req_issue", bus.dmem_req, 1'b1);
    for (int n = 1; n <= TIMEOUT; n++) begin
      if (n == ack_n) begin
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = rdata;
      end else begin
        bus.dmem_rdata = 32'hBAD00000 + 32'(n);
      end
      tick;
      bus.dmem_ack = 1'b0;
      if (n == ack_n) break;
    end
    // DONE: instruction is still presented; a late ack must be ignored.
    if (late_ack) begin
      bus.dmem_ack   = 1'b1;
      bus.dmem_rdata = 32'hFFFFFFFF;
    end
    #1;
    chk("stall_done", bus.stall_mem, 1'b0);
    chk("req_done", bus.dmem_req, 1'b0);
    tick;
    bus.dmem_ack = 1'b0;
    chk("req_after_done", bus.dmem_req, 1'b0);
  endtask

  // Scoreboard monitor
  initial begin : monitor
    int          req_cnt = 0, stall_cnt = 0, bub_cnt = 0;
    logic        prev_req = 1'b0, stable = 1'b1, cap_we = 1'b0;
    logic [31:0] cap_addr = '0, cap_wdata = '0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        req_cnt = 0; stall_cnt = 0; bub_cnt = 0; prev_req = 1'b0; stable = 1'b1;
      end else begin
        if (bus.stall_mem) stall_cnt++;
        if (bus.bubble_wb) bub_cnt++;
        if (bus.dmem_req) begin
          req_cnt++;
          if (!prev_req) begin
            cap_we = bus.dmem_we; cap_addr = bus.dmem_addr; cap_wdata = bus.dmem_wdata;
          end else if (cap_we !== bus.dmem_we || cap_addr !== bus.dmem_addr ||
                       cap_wdata !== bus.dmem_wdata) begin
            stable = 1'b0;
          end
        end else if (prev_req) begin
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL sb_unexpected: completion seen with empty queue");
          end else begin
            e = sb.pop_front();
            chk("sb_we", cap_we, e.we);
            chk("sb_addr", cap_addr, e.addr);
            chk("sb_wdata", cap_wdata, e.wdata);
            chk("sb_stable", stable, 1'b1);
            chk("sb_req_cycles", req_cnt, e.req_cycles);
            chk("sb_stall_cycles", stall_cnt, e.req_cycles + 1);
            chk("sb_bubble_cycles", bub_cnt, e.req_cycles + 1);
            chk("sb_read_data", bus.read_data_m, e.rdata);
            chk("sb_timeout_err", bus.timeout_err, e.terr);
          end
          req_cnt = 0; stall_cnt = 0; bub_cnt = 0; stable = 1'b1;
        end
        prev_req = bus.dmem_req;
      end
    end
  end

  initial begin : stim
    bus.mem_read_m   = 1'b1;
    bus.mem_write_m  = 1'b0;
    bus.alu_out_m    = 32'h00000040;
    bus.write_data_m = '0;
    bus.dmem_ack     = 1'b0;
    bus.dmem_rdata   = '0;
    rst = 1'b0;
    tick; tick;
    chk("rst_req", bus.dmem_req, 1'b0);
    chk("rst_we", bus.dmem_we, 1'b0);
    chk("rst_addr", bus.dmem_addr, 32'h0);
    chk("rst_wdata", bus.dmem_wdata, 32'h0);
    chk("rst_rdata", bus.read_data_m, 32'h0);
    chk("rst_terr", bus.timeout_err, 1'b0);
    chk("rst_stall", bus.stall_mem, 1'b0);
    chk("rst_bubble", bus.bubble_wb, 1'b0);

    // Load released straight out of reset, acked on the 3rd REQ cycle
    do_access(1'b1, 1'b0, 32'h00000040, 32'h0, 32'hDEADBEEF, 3, 1'b0);
    // Store acked in the first REQ cycle; read data keeps the load result
    do_access(1'b0, 1'b1, 32'h00000010, 32'h12345678, 32'h99999999, 1, 1'b0);
    // Read and write both asserted: write wins
    do_access(1'b1, 1'b1, 32'h00000020, 32'hCAFEF00D, 32'h11111111, 2, 1'b0);
    // Back-to-back loads, 3-cycle cadence
    do_access(1'b1, 1'b0, 32'h00000044, 32'h0, 32'hA5A5A5A5, 1, 1'b0);
    do_access(1'b1, 1'b0, 32'h00000048, 32'h0, 32'h5A5A5A5A, 1, 1'b0);
    idle(1);
    chk("nonmem_stall", bus.stall_mem, 1'b0);

    // Timeout with a late ack in DONE and a stray ack in IDLE
    do_access(1'b1, 1'b0, 32'h00000080, 32'h0, 32'h0, 0, 1'b1);
    bus.mem_read_m = 1'b0;
    bus.dmem_ack   = 1'b1;
    bus.dmem_rdata = 32'h13572468;
    tick;
    bus.dmem_ack = 1'b0;
    chk("idle_ack_req", bus.dmem_req, 1'b0);
    chk("idle_ack_rdata", bus.read_data_m, 32'h0);
    chk("terr_sticky", bus.timeout_err, 1'b1);
    do_access(1'b1, 1'b0, 32'h00000084, 32'h0, 32'h0BADF00D, 2, 1'b0);

    // Reset asserted during a REQ cycle
    bus.mem_read_m = 1'b1;
    bus.alu_out_m  = 32'h00000100;
    tick;
    chk("mid_req_up", bus.dmem_req, 1'b1);
    rst = 1'b0;
    bus.dmem_ack   = 1'b1;
    bus.dmem_rdata = 32'h77777777;
    #1;
    chk("mid_rst_stall", bus.stall_mem, 1'b0);
    tick;
    chk("mid_rst_req", bus.dmem_req, 1'b0);
    chk("mid_rst_rdata", bus.read_data_m, 32'h0);
    chk("mid_rst_terr", bus.timeout_err, 1'b0);
    m_rdata = '0; m_terr = 1'b0;
    rst = 1'b1;
    idle(2);
    chk("post_rst_req", bus.dmem_req, 1'b0);
    chk("post_rst_rdata", bus.read_data_m, 32'h0);
    do_access(1'b1, 1'b0, 32'h00000104, 32'h0, 32'h2468ACE0, 1, 1'b0);
    idle(3);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d expected transactions never completed", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sequences every data-memory access from the MEM stage of the pipelined MIPS core over a req/ack handshake to a variable-latency data memory.
- Stalls the upstream pipeline while an access is outstanding.
- Forces bubbles into the MEM/WB register until the access completes, then supplies read data to MEM/WB's read-data input.
- Sits between the EX/MEM register outputs, the data memory, and the MEM/WB register and hazard logic.

Parameters:
- PC_BITS, 32, data and address width.
- TIMEOUT, 255, maximum cycles to wait for dmem_ack in REQ before aborting. Range 1..65535.
- TO_BITS, 16, width of the timeout counter. Must satisfy TIMEOUT < 2^TO_BITS.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-low reset (sampled on posedge clk; low = reset).
- mem_read_m  in  1  load in MEM stage.
- mem_write_m  in  1  store in MEM stage.
- alu_out_m  in  PC_BITS  byte address from EX/MEM.
- write_data_m  in  PC_BITS  store data from EX/MEM.
- dmem_req  out  1  request to data memory; registered.
- dmem_we  out  1  1 = write; registered.
- dmem_addr  out  PC_BITS  registered address.
- dmem_wdata  out  PC_BITS  registered store data.
- dmem_ack  in  1  single-cycle completion pulse from memory.
- dmem_rdata  in  PC_BITS  read data, valid when dmem_ack=1.
- read_data_m  out  PC_BITS  registered load result to MEM/WB read_data input.
- stall_mem  out  1  freeze PC, IF/ID, ID/EX, EX/MEM; combinational from state and inputs.
- bubble_wb  out  1  MEM/WB loads reg_write=0, mem_to_reg=0 this cycle.
- timeout_err  out  1  sticky; set on an aborted access.

Behaviour:
- Reset (rst=0 at posedge):
  - state becomes IDLE; timeout counter = 0.
  - dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, read_data_m=0, timeout_err=0.
  - stall_mem and bubble_wb are forced 0 while rst=0.
- access = mem_read_m | mem_write_m. If both are 1, the access is a write; the read is ignored.
- IDLE:
  - If access: stall_mem=1 and bubble_wb=1 combinationally in the same cycle.
  - At the edge: state goes to REQ; dmem_req<=1; dmem_we<=mem_write_m; dmem_addr<=alu_out_m; dmem_wdata<=write_data_m; counter<=0.
  - If no access: stall_mem=0, bubble_wb=0. dmem_ack in IDLE is ignored.
- REQ:
  - stall_mem=1, bubble_wb=1.
  - dmem_req, dmem_we, dmem_addr and dmem_wdata are held stable.
  - On dmem_ack=1:
    - dmem_req<=0; state goes to DONE.
    - Load: read_data_m<=dmem_rdata. Store: read_data_m is unchanged.
  - Otherwise, counter increments. When counter==TIMEOUT-1 without ack: dmem_req<=0, timeout_err<=1, read_data_m<=0, state goes to DONE.
  - Earliest ack is the first REQ cycle, so minimum access latency is 2 cycles (IDLE + REQ) before DONE.
- DONE:
  - stall_mem=0, bubble_wb=0.
  - MEM/WB captures the completed instruction and read_data_m at the end of this cycle; the pipeline advances.
  - access is ignored in DONE (it still refers to the completed instruction).
  - Next state is always IDLE.
  - Back-to-back accesses therefore cost at least 3 cycles each.
- Non-memory instructions pass through with zero added latency (IDLE, no stall).
- A late ack arriving after a timeout (in DONE or IDLE) is ignored.
- timeout_err is cleared only by reset.
- Reset mid-access: dmem_req drops at the reset edge; any in-flight ack is ignored afterwards.

Test Plan:
- Reset held 2 cycles with mem_read_m=1 -> all outputs 0, stall_mem=0; release -> stall_mem=1 immediately, dmem_req=1 next cycle.
- Load, alu_out_m=0x00000040; ack on 3rd REQ cycle with dmem_rdata=0xDEADBEEF -> dmem_req high exactly 3 cycles; DONE next with read_data_m=0xDEADBEEF, stall_mem=0; stall/bubble high 4 cycles total.
- Store, alu_out_m=0x10, write_data_m=0x12345678, ack in first REQ cycle -> dmem_we=1, dmem_wdata=0x12345678, read_data_m unchanged, stall 2 cycles.
- mem_read_m=mem_write_m=1 -> dmem_we=1 (write wins).
- TIMEOUT=4, no ack -> dmem_req high 4 cycles, timeout_err=1, read_data_m=0, DONE then IDLE; ack injected 1 cycle later is ignored; timeout_err stays 1 until reset.
- Two consecutive loads, each acked in first REQ cycle -> 3-cycle cadence (IDLE, REQ, DONE) per load; no access issued from DONE; rst=0 during a REQ cycle -> dmem_req=0 the next cycle.
